vga_bitmap_writer: RTL and testbench

//  Write side of the 64x64 1-bpp display bitmap that the VGA control path reads.
//  - Accepts a byte stream (e.g. from UART) and packs it MSB-first into 64-bit rows.
//  - Writes those rows into the back bank of an external two-bank row RAM (2 x 64 x 64).
//  - Swaps the banks only during vertical blank, so a frame never tears on screen.

---
 rtl/vga_bitmap_writer_pkg.sv | 27 ++
 rtl/vga_bitmap_writer_row_packer.sv | 40 ++++
 rtl/vga_bitmap_writer.sv | 155 +++++++++++++++
 tb/tb_vga_bitmap_writer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_bitmap_writer_pkg.sv
// Shared constants and state encoding for the bitmap write path.
// The display path imports the same package so both sides agree on geometry.
package vga_bitmap_writer_pkg;

    localparam int ROWS          = 64;
    localparam int ROW_BITS      = 64;
    localparam int BYTES_PER_ROW = ROW_BITS / 8;
    localparam int ADDR_W        = 6;

    // Encoding is fixed so the display side can decode the state if it needs to.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    // True when the row index is the last row of the frame.
    function automatic logic is_last_row(input logic [ADDR_W-1:0] row);
        return row == ADDR_W'(ROWS - 1);
    endfunction

    // True when the byte index is the last byte of a row.
    function automatic logic is_last_byte(input logic [2:0] cnt);
        return cnt == 3'(BYTES_PER_ROW - 1);
    endfunction

endpackage

// File: rtl/vga_bitmap_writer_row_packer.sv
// Packs accepted bytes MSB-first into a 64-bit row and flags each completed row.
// row_full is registered, so it lines up with the row_data that holds the full row.
module vga_bitmap_writer_row_packer
    import vga_bitmap_writer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                shift,
    input  logic                restart,
    input  logic [7:0]          byte_in,
    output logic [ROW_BITS-1:0] row_data,
    output logic [2:0]          byte_cnt,
    output logic                row_full
);

    logic [ROW_BITS-1:0] sreg;
    logic [2:0]          cnt;
    logic                full;

    // Shift register, byte counter and end-of-row strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else begin
            // A restart byte is byte 0 of a new row, so it can never complete one.
            full <= shift && !restart && is_last_byte(cnt);
            if (shift) begin
                sreg <= {sreg[ROW_BITS-9:0], byte_in};
                cnt  <= restart ? 3'd1 : cnt + 3'd1;
            end
        end
    end

    assign row_data = sreg;
    assign byte_cnt = cnt;
    assign row_full = full;

endmodule

// File: rtl/vga_bitmap_writer.sv
// Write side of the double-buffered 64x64 1-bpp bitmap.
// Packs a byte stream into rows, writes them to the back bank, and swaps
// banks only on a vertical-blank pulse once a whole frame has been loaded.
module vga_bitmap_writer
    import vga_bitmap_writer_pkg::*;
(
    input  logic                vga_clk,
    input  logic                rst,
    input  logic [7:0]          Byte_Data,
    input  logic                Byte_Valid,
    input  logic                Byte_Sof,
    output logic                Byte_Ready,
    input  logic                Vblank_Sig,
    output logic                Wr_En,
    output logic                Wr_Bank,
    output logic [ADDR_W-1:0]   Wr_Addr,
    output logic [ROW_BITS-1:0] Wr_Data,
    output logic                Bank_Sel,
    output logic                Frame_Done,
    output logic                Frame_Err
);

    state_t              state;
    state_t              next_state;
    logic                ready;
    logic                accept;
    logic                pack_shift;
    logic                pack_restart;
    logic                row_end;
    logic                err_set;
    logic                swap;
    logic [ADDR_W-1:0]   row;
    logic [ADDR_W-1:0]   wr_addr;
    logic                bank_sel;
    logic                frame_done;
    logic                frame_err;
    logic [2:0]          byte_cnt;
    logic [ROW_BITS-1:0] row_data;
    logic                row_full;

    vga_bitmap_writer_row_packer u_packer (
        .clk      (vga_clk),
        .rst      (rst),
        .shift    (pack_shift),
        .restart  (pack_restart),
        .byte_in  (Byte_Data),
        .row_data (row_data),
        .byte_cnt (byte_cnt),
        .row_full (row_full)
    );

    // State register.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode, handshake and per-cycle control strobes.
    always_comb begin
        next_state   = state;
        ready        = 1'b0;
        accept       = 1'b0;
        pack_shift   = 1'b0;
        pack_restart = 1'b0;
        row_end      = 1'b0;
        err_set      = 1'b0;
        swap         = 1'b0;

        // Holding ready low in WAIT_SWAP makes the source keep its byte.
        ready  = !rst && ((state == IDLE) || (state == LOAD));
        accept = Byte_Valid && ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (Byte_Sof) begin
                        pack_shift   = 1'b1;
                        pack_restart = 1'b1;
                        next_state   = LOAD;
                    end else begin
                        // Bytes outside a frame are dropped and flagged.
                        err_set = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    pack_shift = 1'b1;
                    if (Byte_Sof) begin
                        // Resync: restart the frame in the same back bank.
                        pack_restart = 1'b1;
                        err_set      = 1'b1;
                    end else if (is_last_byte(byte_cnt)) begin
                        row_end = 1'b1;
                        if (is_last_row(row)) begin
                            next_state = WAIT_SWAP;
                        end
                    end
                end
                // Vblank is deliberately ignored here, including on the
                // cycle that completes row 63.
            end
            WAIT_SWAP: begin
                if (Vblank_Sig) begin
                    swap       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Row counter and the address latched for the outgoing row write.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            row     <= '0;
            wr_addr <= '0;
        end else if (pack_restart) begin
            row <= '0;
        end else if (row_end) begin
            wr_addr <= row;
            row     <= row + 1'b1;
        end
    end

    // Bank select and the one-cycle status pulses.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            bank_sel   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= swap;
            frame_err  <= err_set;
            if (swap) begin
                bank_sel <= ~bank_sel;
            end
        end
    end

    assign Byte_Ready = ready;
    assign Wr_En      = row_full;
    assign Wr_Addr    = wr_addr;
    assign Wr_Data    = row_data;
    assign Wr_Bank    = ~bank_sel;
    assign Bank_Sel   = bank_sel;
    assign Frame_Done = frame_done;
    assign Frame_Err  = frame_err;

endmodule

// File: tb/tb_vga_bitmap_writer.sv
// Self-checking bench for vga_bitmap_writer: a vector table for the
// single-cycle behaviour, then directed frame-level sequences.
module tb_vga_bitmap_writer;

    logic        vga_clk;
    logic        rst;
    logic [7:0]  Byte_Data;
    logic        Byte_Valid;
    logic        Byte_Sof;
    logic        Byte_Ready;
    logic        Vblank_Sig;
    logic        Wr_En;
    logic        Wr_Bank;
    logic [5:0]  Wr_Addr;
    logic [63:0] Wr_Data;
    logic        Bank_Sel;
    logic        Frame_Done;
    logic        Frame_Err;

    vga_bitmap_writer dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .Byte_Data  (Byte_Data),
        .Byte_Valid (Byte_Valid),
        .Byte_Sof   (Byte_Sof),
        .Byte_Ready (Byte_Ready),
        .Vblank_Sig (Vblank_Sig),
        .Wr_En      (Wr_En),
        .Wr_Bank    (Wr_Bank),
        .Wr_Addr    (Wr_Addr),
        .Wr_Data    (Wr_Data),
        .Bank_Sel   (Bank_Sel),
        .Frame_Done (Frame_Done),
        .Frame_Err  (Frame_Err)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Write-side expectations used by the monitor.
    int   exp_row  = 0;
    int   exp_kind = 0;
    logic exp_bank = 1'b1;
    int   wr_cnt   = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame content patterns, indexed by byte position within the frame.
    function automatic logic [7:0] byte_of(input int kind, input int i);
        logic [31:0] v;
        v = i;
        case (kind)
            0:       return (i == 0) ? 8'h80 : ((i == 7) ? 8'h01 : 8'h00);
            1:       return v[7:0] ^ 8'h5A;
            default: begin
                v = i * 3;
                return (i == 0) ? 8'hA5 : v[7:0];
            end
        endcase
    endfunction

    function automatic logic [63:0] row_exp(input int kind, input int r);
        logic [63:0] acc;
        acc = '0;
        for (int b = 0; b < 8; b++) acc = {acc[55:0], byte_of(kind, r * 8 + b)};
        return acc;
    endfunction

    // Monitor: every row write must be the next row, in the back bank, with the packed data.
    always @(negedge vga_clk) begin
        if (Frame_Done === 1'b1) done_cnt++;
        if (Frame_Err === 1'b1) err_cnt++;
        if (Wr_En === 1'b1) begin
            check("wr_addr", 64'(Wr_Addr), 64'(exp_row));
            check("wr_bank", 64'(Wr_Bank), 64'(exp_bank));
            check("wr_data", Wr_Data, row_exp(exp_kind, exp_row));
            exp_row = (exp_row + 1) % 64;
            wr_cnt++;
        end
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // Presents one byte and waits (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] d, input logic sof, input logic vb);
        int waited;
        waited     = 0;
        Byte_Data  = d;
        Byte_Sof   = sof;
        Byte_Valid = 1'b1;
        Vblank_Sig = vb;
        while (Byte_Ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (Byte_Ready !== 1'b1) check("accept_timeout", 64'd0, 64'd1);
        tick();
        Vblank_Sig = 1'b0;
    endtask

    task automatic send_range(input int kind, input int first, input int last,
                              input int vb_a, input int vb_b);
        for (int i = first; i <= last; i++)
            send_byte(byte_of(kind, i), i == 0, (i == vb_a) || (i == vb_b));
        Byte_Valid = 1'b0;
        Byte_Sof   = 1'b0;
    endtask

    task automatic vblank_pulse();
        Vblank_Sig = 1'b1;
        tick();
        Vblank_Sig = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          valid;
        bit          sof;
        bit          vblank;
        logic [7:0]  data;
        bit          ready;
        bit          err;
        bit          done;
        bit          wr_en;
        bit          bank;
        logic [63:0] wdata;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int e0;
        int d0;

        rst        = 1'b1;
        Byte_Data  = 8'h00;
        Byte_Valid = 1'b0;
        Byte_Sof   = 1'b0;
        Vblank_Sig = 1'b0;

        //            rst   valid sof   vblank data    ready err   done  wr_en bank  wdata
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA5};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA53C};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA53C};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'hA53C11};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA53C1122};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA53C1122};

        for (int k = 0; k < 9; k++) begin
            rst        = tbl[k].rst;
            Byte_Valid = tbl[k].valid;
            Byte_Sof   = tbl[k].sof;
            Vblank_Sig = tbl[k].vblank;
            Byte_Data  = tbl[k].data;
            tick();
            check($sformatf("vec%0d_ready", k), 64'(Byte_Ready), 64'(tbl[k].ready));
            check($sformatf("vec%0d_err", k),   64'(Frame_Err),  64'(tbl[k].err));
            check($sformatf("vec%0d_done", k),  64'(Frame_Done), 64'(tbl[k].done));
            check($sformatf("vec%0d_wr_en", k), 64'(Wr_En),      64'(tbl[k].wr_en));
            check($sformatf("vec%0d_bank", k),  64'(Bank_Sel),   64'(tbl[k].bank));
            check($sformatf("vec%0d_wdata", k), Wr_Data,         tbl[k].wdata);
        end
        Byte_Valid = 1'b0;
        Byte_Sof   = 1'b0;
        Vblank_Sig = 1'b0;

        // Clean start for the frame sequences.
        rst = 1'b1;
        tick();
        check("rst_wr_addr", 64'(Wr_Addr), 64'd0);
        rst = 1'b0;
        tick();

        // Full frame into bank 1.
        exp_kind = 0; exp_bank = 1'b1; exp_row = 0;
        w0 = wr_cnt;
        send_range(0, 0, 511, -1, -1);
        tick();
        check("f1_writes", 64'(wr_cnt - w0), 64'd64);
        check("f1_ready_wait", 64'(Byte_Ready), 64'd0);
        check("f1_bank_hold", 64'(Bank_Sel), 64'd0);
        repeat (4) tick();
        check("f1_no_wr_in_wait", 64'(wr_cnt - w0), 64'd64);

        // Swap on vblank.
        d0 = done_cnt;
        vblank_pulse();
        check("swap1_bank", 64'(Bank_Sel), 64'd1);
        check("swap1_done", 64'(Frame_Done), 64'd1);
        check("swap1_ready", 64'(Byte_Ready), 64'd1);
        tick();
        check("swap1_done_pulse", 64'(Frame_Done), 64'd0);
        check("swap1_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Next frame writes bank 0; early vblanks must not swap.
        exp_kind = 1; exp_bank = 1'b0; exp_row = 0;
        w0 = wr_cnt; d0 = done_cnt;
        send_range(1, 0, 511, 300, 511);
        tick();
        check("f2_writes", 64'(wr_cnt - w0), 64'd64);
        check("early_vb_bank", 64'(Bank_Sel), 64'd1);
        check("early_vb_done", 64'(done_cnt - d0), 64'd0);

        // Hold an SOF byte across WAIT_SWAP; it must wait for the swap.
        Byte_Data = 8'hA5; Byte_Sof = 1'b1; Byte_Valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_ready_low", 64'(Byte_Ready), 64'd0);
        end
        check("bp_no_wr", 64'(wr_cnt - w0), 64'd64);
        exp_kind = 2; exp_bank = 1'b1; exp_row = 0;
        vblank_pulse();
        check("swap2_bank", 64'(Bank_Sel), 64'd0);
        check("swap2_done", 64'(Frame_Done), 64'd1);
        check("swap2_ready", 64'(Byte_Ready), 64'd1);
        tick();
        check("bp_byte_loaded", 64'(Wr_Data[7:0]), 64'hA5);
        Byte_Sof = 1'b0;
        w0 = wr_cnt;
        send_range(2, 1, 511, -1, -1);
        tick();
        check("f3_writes", 64'(wr_cnt - w0), 64'd64);
        vblank_pulse();
        check("swap3_bank", 64'(Bank_Sel), 64'd1);

        // Reset partway into row 20 of the next frame.
        exp_kind = 1; exp_bank = 1'b0; exp_row = 0;
        w0 = wr_cnt;
        send_range(1, 0, 162, -1, -1);
        check("pre_rst_writes", 64'(wr_cnt - w0), 64'd20);
        rst = 1'b1;
        tick();
        check("rst_wr_en", 64'(Wr_En), 64'd0);
        check("rst_addr", 64'(Wr_Addr), 64'd0);
        check("rst_data", Wr_Data, 64'd0);
        check("rst_bank", 64'(Bank_Sel), 64'd0);
        check("rst_done", 64'(Frame_Done), 64'd0);
        check("rst_err", 64'(Frame_Err), 64'd0);
        check("rst_ready", 64'(Byte_Ready), 64'd0);
        rst = 1'b0;
        exp_row = 0; exp_bank = 1'b1;
        tick();

        // Junk byte in IDLE: error pulse, no write.
        e0 = err_cnt; w0 = wr_cnt;
        send_byte(8'hFF, 1'b0, 1'b0);
        Byte_Valid = 1'b0;
        tick();
        check("junk_err", 64'(err_cnt - e0), 64'd1);
        check("junk_no_wr", 64'(wr_cnt - w0), 64'd0);
        check("junk_idle_ready", 64'(Byte_Ready), 64'd1);

        // Resync: SOF at byte 100 restarts at row 0, then a full frame.
        w0 = wr_cnt;
        send_range(1, 0, 99, -1, -1);
        check("resync_pre_writes", 64'(wr_cnt - w0), 64'd12);
        exp_row = 0;
        e0 = err_cnt;
        send_range(1, 0, 511, -1, -1);
        tick();
        check("resync_err", 64'(err_cnt - e0), 64'd1);
        check("resync_writes", 64'(wr_cnt - w0), 64'd76);
        check("resync_ready_wait", 64'(Byte_Ready), 64'd0);
        vblank_pulse();
        check("swap4_bank", 64'(Bank_Sel), 64'd1);
        check("swap4_done", 64'(Frame_Done), 64'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
